// File: rtl/keras_1layer_pkg.sv
// Shared constants for the single-neuron Keras layer: word format, trained
// weights and bias, size constants and the controller state encoding.
package keras_1layer_pkg;

    localparam int N_IN = 10;
    localparam int DW   = 18;
    localparam int FB   = 10;
    localparam int PW   = 2 * DW;
    localparam int AW   = 40;

    // Raw ap_fixed<18,8> codes, LSB = 2^-10.
    localparam logic signed [DW-1:0] WEIGHTS [N_IN] = '{
        18'sd1024, -18'sd512, 18'sd256, 18'sd2048, -18'sd1024,
        18'sd512, 18'sd1024, -18'sd2048, 18'sd768, 18'sd128
    };
    localparam logic signed [DW-1:0] BIAS = 18'sd512;

    localparam logic [15:0] SIZE_IN  = 16'd10;
    localparam logic [15:0] SIZE_OUT = 16'd1;

    localparam logic [3:0] LAST_LANE = 4'(N_IN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_ACT  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/keras_1layer_if.sv
// Catapult-style channel bundle of the layer: input vector, result and the
// two constant size channels, each with its triosy completion strobe.
interface keras_1layer_if;
    import keras_1layer_pkg::*;

    // Handshake: a transfer happens on a rising clk edge where vld && rdy;
    // the producer holds dat/vld stable until that edge.
    logic [N_IN*DW-1:0] input_1_rsc_dat;
    logic               input_1_rsc_vld;
    logic               input_1_rsc_rdy;
    logic               input_1_rsc_triosy_lz;

    logic [DW-1:0]      layer5_out_rsc_dat;
    logic               layer5_out_rsc_vld;
    logic               layer5_out_rsc_rdy;
    logic               layer5_out_rsc_triosy_lz;

    logic [15:0]        const_size_in_1_rsc_dat;
    logic               const_size_in_1_rsc_vld;
    logic               const_size_in_1_rsc_triosy_lz;
    logic [15:0]        const_size_out_1_rsc_dat;
    logic               const_size_out_1_rsc_vld;
    logic               const_size_out_1_rsc_triosy_lz;

    modport slave (
        input  input_1_rsc_dat, input_1_rsc_vld, layer5_out_rsc_rdy,
        output input_1_rsc_rdy, input_1_rsc_triosy_lz,
        output layer5_out_rsc_dat, layer5_out_rsc_vld, layer5_out_rsc_triosy_lz,
        output const_size_in_1_rsc_dat, const_size_in_1_rsc_vld, const_size_in_1_rsc_triosy_lz,
        output const_size_out_1_rsc_dat, const_size_out_1_rsc_vld, const_size_out_1_rsc_triosy_lz
    );

    modport master (
        output input_1_rsc_dat, input_1_rsc_vld, layer5_out_rsc_rdy,
        input  input_1_rsc_rdy, input_1_rsc_triosy_lz,
        input  layer5_out_rsc_dat, layer5_out_rsc_vld, layer5_out_rsc_triosy_lz,
        input  const_size_in_1_rsc_dat, const_size_in_1_rsc_vld, const_size_in_1_rsc_triosy_lz,
        input  const_size_out_1_rsc_dat, const_size_out_1_rsc_vld, const_size_out_1_rsc_triosy_lz
    );

endinterface

// File: rtl/keras_1layer_act.sv
// Output stage: aligned bias add, floor shift back to 10 fraction bits,
// ReLU and saturation to the largest positive 18-bit code.
module keras_1layer_act
    import keras_1layer_pkg::*;
(
    input  logic signed [AW-1:0] acc,
    output logic        [DW-1:0] y
);

    localparam logic signed [AW-1:0] BIAS_ALIGNED = AW'(BIAS) <<< FB;
    localparam logic signed [AW-1:0] SAT_MAX      = (AW'(1) <<< (DW - 1)) - AW'(1);

    logic signed [AW-1:0] biased;
    logic signed [AW-1:0] shifted;

    always_comb begin
        biased  = acc + BIAS_ALIGNED;
        shifted = biased >>> FB;
        y       = '0;
        if (shifted[AW-1]) begin
            y = '0;
        end else if (shifted > SAT_MAX) begin
            y = SAT_MAX[DW-1:0];
        end else begin
            y = shifted[DW-1:0];
        end
    end

endmodule

// File: rtl/keras_1layer.sv
// Single Dense(1)+ReLU neuron over 10 lanes: one multiply-accumulate per
// cycle, one vector in flight, result held until the consumer takes it.
module keras_1layer
    import keras_1layer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    keras_1layer_if.slave  bus,
    output state_t         fsm_state
);

    state_t               state;
    logic signed [DW-1:0] lane_q [N_IN];
    logic [3:0]           cnt;
    logic signed [AW-1:0] acc;
    logic signed [PW-1:0] prod;
    logic [DW-1:0]        act_y;
    logic [DW-1:0]        out_dat;
    logic                 out_vld;
    logic                 done_q;
    logic                 accept;
    logic                 out_fire;

    assign accept   = (state == ST_IDLE) && !rst && bus.input_1_rsc_vld;
    assign out_fire = (state == ST_OUT) && bus.layer5_out_rsc_rdy;
    assign prod     = lane_q[cnt] * WEIGHTS[cnt];

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N_IN; i++) begin
                lane_q[i] <= bus.input_1_rsc_dat[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            out_dat <= '0;
            out_vld <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= out_fire;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + AW'(prod);
                    if (cnt == LAST_LANE) begin
                        cnt   <= '0;
                        state <= ST_ACT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_ACT: begin
                    out_dat <= act_y;
                    out_vld <= 1'b1;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_fire) begin
                        out_vld <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    keras_1layer_act u_act (
        .acc (acc),
        .y   (act_y)
    );

    // Completion strobes are forced low during reset so an abort never leaks one.
    assign bus.input_1_rsc_rdy                = (state == ST_IDLE) && !rst;
    assign bus.input_1_rsc_triosy_lz          = done_q && !rst;
    assign bus.layer5_out_rsc_dat             = out_dat;
    assign bus.layer5_out_rsc_vld             = out_vld;
    assign bus.layer5_out_rsc_triosy_lz       = done_q && !rst;
    assign bus.const_size_in_1_rsc_dat        = SIZE_IN;
    assign bus.const_size_in_1_rsc_vld        = !rst;
    assign bus.const_size_in_1_rsc_triosy_lz  = done_q && !rst;
    assign bus.const_size_out_1_rsc_dat       = SIZE_OUT;
    assign bus.const_size_out_1_rsc_vld       = !rst;
    assign bus.const_size_out_1_rsc_triosy_lz = done_q && !rst;
    assign fsm_state                          = state;

endmodule

// File: tb/tb_keras_1layer.sv
// Bench for keras_1layer: table of vectors with fixed expectations, plus
// backpressure, mid-compute reset and back-to-back throughput sequences.
module tb_keras_1layer;
    import keras_1layer_pkg::*;

    logic   clk;
    logic   rst;
    state_t fsm_state;
    int     total;
    int     bad;
    logic [17:0] exp_q[$];

    keras_1layer_if bus ();

    keras_1layer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] triosy();
        return {bus.input_1_rsc_triosy_lz, bus.layer5_out_rsc_triosy_lz,
                bus.const_size_in_1_rsc_triosy_lz, bus.const_size_out_1_rsc_triosy_lz};
    endfunction

    // Independent reference: integer dot product with the trained weights.
    function automatic logic [17:0] model(input logic [179:0] v);
        longint s;
        longint w [10];
        logic [17:0] r;
        w = '{1024, -512, 256, 2048, -1024, 512, 1024, -2048, 768, 128};
        s = 0;
        for (int i = 0; i < 10; i++) begin
            s += longint'($signed(v[i*18 +: 18])) * w[i];
        end
        s = s + 512 * 1024;
        s = s >>> 10;
        if (s < 0) r = 18'h00000;
        else if (s > 131071) r = 18'h1FFFF;
        else r = s[17:0];
        return r;
    endfunction

    function automatic logic [179:0] one_lane(input int idx, input logic [17:0] val);
        logic [179:0] v;
        v = '0;
        v[idx*18 +: 18] = val;
        return v;
    endfunction

    function automatic logic [179:0] rand_vec();
        logic [179:0] v;
        for (int i = 0; i < 10; i++) v[i*18 +: 18] = 18'($urandom);
        return v;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("const_in_dat", bus.const_size_in_1_rsc_dat, 16'd10);
            chk("const_out_dat", bus.const_size_out_1_rsc_dat, 16'd1);
            chk("const_vld", {bus.const_size_in_1_rsc_vld, bus.const_size_out_1_rsc_vld}, 2'b11);
            if (bus.layer5_out_rsc_vld && bus.layer5_out_rsc_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", bus.layer5_out_rsc_dat, 18'h3FFFF);
                    if (bus.layer5_out_rsc_dat === 18'h3FFFF) begin
                        bad++;
                        $display("FAIL unexpected_result: got output want none");
                    end
                end else begin
                    chk("result", bus.layer5_out_rsc_dat, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_vec(input logic [179:0] v, input logic [17:0] exp, input int hold);
        int t;
        logic [17:0] held;
        t = 0;
        while (!bus.input_1_rsc_rdy && t < 40) begin
            @(posedge clk); #1; t++;
        end
        chk("in_rdy_idle", bus.input_1_rsc_rdy, 1'b1);
        bus.input_1_rsc_dat = v;
        bus.input_1_rsc_vld = 1'b1;
        if (hold > 0) bus.layer5_out_rsc_rdy = 1'b0;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        bus.input_1_rsc_vld = 1'b0;
        bus.input_1_rsc_dat = rand_vec();
        chk("in_rdy_busy", bus.input_1_rsc_rdy, 1'b0);
        t = 0;
        while (!bus.layer5_out_rsc_vld && t < 30) begin
            @(posedge clk); #1; t++;
        end
        chk("latency", t, 11);
        if (hold > 0) begin
            held = bus.layer5_out_rsc_dat;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                chk("hold_vld", bus.layer5_out_rsc_vld, 1'b1);
                chk("hold_dat", bus.layer5_out_rsc_dat, held);
                chk("hold_in_rdy", bus.input_1_rsc_rdy, 1'b0);
                chk("hold_triosy", triosy(), 4'b0000);
            end
            bus.layer5_out_rsc_rdy = 1'b1;
        end
        @(posedge clk); #1;
        chk("triosy_pulse", triosy(), 4'b1111);
        chk("vld_drop", bus.layer5_out_rsc_vld, 1'b0);
        chk("in_rdy_after", bus.input_1_rsc_rdy, 1'b1);
        @(posedge clk); #1;
        chk("triosy_end", triosy(), 4'b0000);
    endtask

    typedef struct {
        logic [179:0] dat;
        logic [17:0]  exp;
    } vec_t;

    vec_t tbl [8];
    longint acc_t [3];

    // ---------------- main sequence ----------------
    initial begin
        int t;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.input_1_rsc_dat    = '0;
        bus.input_1_rsc_vld    = 1'b0;
        bus.layer5_out_rsc_rdy = 1'b1;

        tbl[0] = '{'0, 18'h00200};
        tbl[1] = '{one_lane(0, 18'h00400), 18'h00600};
        tbl[2] = '{one_lane(4, 18'h00800), 18'h00000};
        tbl[3] = '{one_lane(3, 18'h1FFFF), 18'h1FFFF};
        tbl[4] = '{one_lane(7, 18'h3F800), 18'h01200};
        for (int i = 5; i < 8; i++) begin
            tbl[i].dat = rand_vec();
            tbl[i].exp = model(tbl[i].dat);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", bus.input_1_rsc_rdy, 1'b0);
        chk("rst_triosy", triosy(), 4'b0000);
        chk("rst_const_vld", {bus.const_size_in_1_rsc_vld, bus.const_size_out_1_rsc_vld}, 2'b00);
        chk("rst_state", fsm_state, 2'd0);
        chk("rst_out_vld", bus.layer5_out_rsc_vld, 1'b0);
        chk("rst_out_dat", bus.layer5_out_rsc_dat, 18'h0);
        rst = 1'b0;
        #1;
        chk("in_rdy_post_rst", bus.input_1_rsc_rdy, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i].dat, tbl[i].exp, 0);
        end

        // Consumer stalls for five cycles.
        run_vec(one_lane(0, 18'h00400), 18'h00600, 5);

        // Reset lands in MAC cycle 5; the aborted vector must never surface.
        t = 0;
        while (!bus.input_1_rsc_rdy && t < 40) begin
            @(posedge clk); #1; t++;
        end
        bus.input_1_rsc_dat = one_lane(3, 18'h1FFFF);
        bus.input_1_rsc_vld = 1'b1;
        @(posedge clk); #1;
        bus.input_1_rsc_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mac_state", fsm_state, 2'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_state", fsm_state, 2'd0);
        chk("abort_out_vld", bus.layer5_out_rsc_vld, 1'b0);
        chk("abort_triosy", triosy(), 4'b0000);
        chk("abort_in_rdy", bus.input_1_rsc_rdy, 1'b0);
        rst = 1'b0;
        #1;
        chk("abort_in_rdy_after", bus.input_1_rsc_rdy, 1'b1);
        run_vec(one_lane(0, 18'h00400), 18'h00600, 0);

        // Back-to-back: vld held high, new data offered immediately after each accept.
        bus.input_1_rsc_dat = rand_vec();
        bus.input_1_rsc_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!bus.input_1_rsc_rdy && t < 40) begin
                @(posedge clk); #1; t++;
            end
            chk("tp_in_rdy", bus.input_1_rsc_rdy, 1'b1);
            @(posedge clk);
            exp_q.push_back(model(bus.input_1_rsc_dat));
            acc_t[k] = longint'($time);
            #1;
            bus.input_1_rsc_dat = rand_vec();
        end
        bus.input_1_rsc_vld = 1'b0;
        chk("tp_period0", acc_t[1] - acc_t[0], 130);
        chk("tp_period1", acc_t[2] - acc_t[1], 130);

        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
